alu_cc_unit: RTL and testbench
==============================

# alu_cc_unit

Execute stage directly downstream of the register file: consumes the SR1/SR2 read values plus the current IR and produces the registered ALU result that is gated onto the datapath bus. It also owns the N/Z/P condition-code register, which is loaded from the same bus value that the register file writes. An optional multi-cycle multiply extends the basic four operations: ADD, AND, NOT and PASSA.

## Interface
Parameters:
- RESET_CC, 3'b010, N/Z/P value loaded on reset; must be one-hot.

Ports:
- i_CLK  in  1  system clock; all state updates on its rising edge.
- i_RST  in  1  synchronous reset, active-high.
- i_SR1  in  16  source register 1 value from the register file.
- i_SR2  in  16  source register 2 value from the register file.
- i_IR  in  16  instruction register; bit 5 selects the immediate, bits 4:0 are imm5.
- i_ALUK  in  2  operation select: 00 ADD, 01 AND, 10 NOT, 11 PASSA.
- i_MUL  in  1  request a multiply instead of the i_ALUK operation; ignored unless ALU_MUL_EN is defined.
- i_START  in  1  launch an operation; sampled at the rising edge.
- i_LD_CC  in  1  load the condition codes from i_bus.
- i_bus  in  16  datapath bus value.
- o_ALU  out  16  registered result; held until the next completion.
- o_VALID  out  1  one-cycle pulse: o_ALU was updated this cycle.
- o_BUSY  out  1  high while a multiply is in progress.
- o_N, o_Z, o_P  out  1 each  condition codes.

## Operation
- Operand B: if i_IR[5] is 1, B is i_IR[4:0] sign-extended to 16 bits; otherwise B is i_SR2. Operand A is i_SR1.
- ADD: A+B modulo 2^16; no carry or overflow output.
- AND: A&B. NOT: ~A. PASSA: A.
- States are IDLE and MUL. MUL is only reachable when ALU_MUL_EN is defined.
- IDLE with i_START=1 and i_MUL=0: o_ALU is loaded with the result at that edge, o_VALID goes to 1, and the state stays IDLE.
- IDLE with i_START=1 and i_MUL=1:
  - Latch A and B; clear the accumulator and the 4-bit bit counter.
  - Go to MUL; o_BUSY goes to 1.
- MUL, each edge: if B[count] is 1, acc += A<<count (16-bit truncated). Then count increments.
- MUL, on the edge where count is 15:
  - o_ALU is loaded with the final acc and o_VALID goes to 1.
  - o_BUSY goes to 0 and the state returns to IDLE.
- The product is the low 16 bits of the product, which is identical for signed and unsigned operands.
- i_START in MUL is ignored: not queued and no effect.
- Back-to-back operations: i_START in the cycle where o_VALID is 1 and the state is IDLE is accepted.
- Condition codes:
  - On an edge with i_LD_CC=1: N = i_bus[15]; Z = (i_bus == 0); P = the remaining case.
  - The N/Z/P register is always one-hot.
  - The condition codes are independent of the ALU state and of i_START.
- Inputs are not re-sampled during MUL, so register-file writes during a multiply do not corrupt it.

## Timing
- Reset values: o_ALU=0, o_VALID=0, o_BUSY=0, state IDLE, {o_N,o_Z,o_P}=RESET_CC.
- Reset has priority over i_START and i_LD_CC in the same cycle.
- Reset during MUL aborts the multiply: no o_VALID pulse, and o_ALU is cleared.
- Simple operation: i_START sampled at edge k, so o_ALU and o_VALID are valid after edge k. Latency is 1 cycle; throughput is 1 per cycle.
- Multiply: i_START at edge k puts o_BUSY high after edge k. o_VALID is high and o_BUSY is low after edge k+16, so o_BUSY is high for exactly 16 cycles.
- o_VALID is never high for two consecutive cycles from a single request.
- Condition codes: i_LD_CC at edge k, so the new N/Z/P are visible after edge k.
- i_bus must be stable at that edge.

## Configuration
- ALU_MUL_EN defined:
  - The MUL state, the multiplier datapath and the 16-cycle sequencing are compiled in.
  - i_MUL=1 selects multiply.
- ALU_MUL_EN undefined:
  - No MUL state and no multiplier datapath.
  - o_BUSY is tied to 0 and i_MUL is ignored.
  - Every i_START completes in 1 cycle using i_ALUK.

## Test plan
- Reset, then check outputs: o_ALU=0x0000, o_VALID=0, o_BUSY=0, N/Z/P=0/1/0. Then set i_SR1=0x0005, i_IR[5:0]=6'b111101 (imm -3), ADD, i_START -> o_ALU=0x0002 with a one-cycle o_VALID.
- Register operand: i_IR[5]=0, i_SR1=0x7FFF, i_SR2=0x0001, ADD -> o_ALU=0x8000. Repeat with AND of 0xF0F0 and 0x0FF0 -> 0x00F0. Then NOT of 0x00FF -> 0xFF00 on the next cycle (back-to-back).
- Condition codes: i_LD_CC with i_bus=0x8000 -> N=1. With i_bus=0x0000 -> Z=1. With i_bus=0x0001 -> P=1. Assert one-hot on every cycle.
- Multiply (macro on): i_SR1=0x0003, i_SR2=0xFFFF, i_MUL=1 -> o_BUSY high for 16 cycles, then o_ALU=0xFFFD with one o_VALID pulse. An i_START at busy cycle 5 is ignored, and i_SR1 changing mid-operation has no effect.
- Reset at busy cycle 8 -> o_BUSY=0, o_ALU=0, no o_VALID. A new ADD issued the next cycle completes normally.
- Macro off: i_MUL=1 with ALUK=ADD, i_SR1=2, i_SR2=3 -> o_ALU=0x0005 after 1 cycle, and o_BUSY stays 0 throughout.

Source files
------------

// File: rtl/alu_cc_unit.sv
// alu_cc_unit: execute-stage ALU (ADD/AND/NOT/PASSA) with N/Z/P register.
// Define ALU_MUL_EN to compile in the 16-cycle shift-add multiplier.
module alu_cc_unit #(
  parameter logic [2:0] RESET_CC = 3'b010
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_SR1,
  input  logic [15:0] i_SR2,
  input  logic [15:0] i_IR,
  input  logic [1:0]  i_ALUK,
  input  logic        i_MUL,
  input  logic        i_START,
  input  logic        i_LD_CC,
  input  logic [15:0] i_bus,
  output logic [15:0] o_ALU,
  output logic        o_VALID,
  output logic        o_BUSY,
  output logic        o_N,
  output logic        o_Z,
  output logic        o_P
);

  logic [15:0] opb;
  logic [15:0] res;
  logic [15:0] alu_q, alu_d;
  logic        vld_q, vld_d;
  logic [2:0]  cc_q, cc_d;

  // IR[15:6] belong to other stages' decode
  logic [9:0]  unused_ir;
  assign unused_ir = i_IR[15:6];

  // operand B: sign-extended imm5 or SR2
  always_comb begin
    opb = i_SR2;
    if (i_IR[5])
      opb = {{11{i_IR[4]}}, i_IR[4:0]};
  end

  // single-cycle operation select
  always_comb begin
    res = '0;
    unique case (i_ALUK)
      2'b00:   res = i_SR1 + opb;
      2'b01:   res = i_SR1 & opb;
      2'b10:   res = ~i_SR1;
      2'b11:   res = i_SR1;
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] a_q, b_q;
  logic [15:0] acc_q, acc_sum;
  logic [3:0]  cnt_q;
  logic        go_mul, go_alu, mul_last;

  assign go_mul   = (state_q == S_IDLE) & i_START & i_MUL;
  assign go_alu   = (state_q == S_IDLE) & i_START & ~i_MUL;
  assign mul_last = (state_q == S_MUL) & (cnt_q == 4'd15);

  // one shift-add partial product per cycle, LSB of B first
  always_comb begin
    acc_sum = acc_q;
    if (b_q[cnt_q])
      acc_sum = acc_q + (a_q << cnt_q);
  end

  // state register
  always_ff @(posedge i_CLK) begin
    if (i_RST)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // next-state: START ignored while multiplying
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (go_mul) state_d = S_MUL;
      S_MUL:   if (cnt_q == 4'd15) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // outputs: completion from either path, busy while in MUL
  always_comb begin
    alu_d  = alu_q;
    vld_d  = 1'b0;
    o_BUSY = (state_q == S_MUL);
    if (go_alu) begin
      alu_d = res;
      vld_d = 1'b1;
    end
    if (mul_last) begin
      alu_d = acc_sum;
      vld_d = 1'b1;
    end
  end

  // multiplier datapath: operands latched once, so RF writes are harmless
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (go_mul) begin
      a_q   <= i_SR1;
      b_q   <= opb;
      acc_q <= '0;
      cnt_q <= '0;
    end else if (state_q == S_MUL) begin
      acc_q <= acc_sum;
      cnt_q <= cnt_q + 4'd1;
    end
  end

`else

  logic unused_mul;
  assign unused_mul = i_MUL;

  // every START completes in one cycle
  always_comb begin
    alu_d  = alu_q;
    vld_d  = i_START;
    o_BUSY = 1'b0;
    if (i_START)
      alu_d = res;
  end

`endif

  // result register and completion pulse
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      alu_q <= '0;
      vld_q <= 1'b0;
    end else begin
      alu_q <= alu_d;
      vld_q <= vld_d;
    end
  end

  // N/Z/P decode of the bus value, always one-hot
  always_comb begin
    cc_d = cc_q;
    if (i_LD_CC) begin
      cc_d[2] = i_bus[15];
      cc_d[1] = (i_bus == 16'h0000);
      cc_d[0] = ~i_bus[15] & (i_bus != 16'h0000);
    end
  end

  // condition-code register
  always_ff @(posedge i_CLK) begin
    if (i_RST)
      cc_q <= RESET_CC;
    else
      cc_q <= cc_d;
  end

  assign o_ALU   = alu_q;
  assign o_VALID = vld_q;
  assign o_N     = cc_q[2];
  assign o_Z     = cc_q[1];
  assign o_P     = cc_q[0];

endmodule

// File: tb/tb_alu_cc_unit.sv
// tb_alu_cc_unit: directed and random checks of alu_cc_unit
// against an arithmetic reference model.
module tb_alu_cc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sr1, sr2, ir, bus;
  logic [1:0]  aluk;
  logic        mul, start, ldcc;
  logic [15:0] alu;
  logic        vld, busy, n, z, p;

  int n_pass = 0;
  int n_chk  = 0;

  logic [15:0] e_alu;
  logic [2:0]  e_cc;

  alu_cc_unit #(.RESET_CC(3'b010)) dut (
    .i_CLK   (clk),
    .i_RST   (rst),
    .i_SR1   (sr1),
    .i_SR2   (sr2),
    .i_IR    (ir),
    .i_ALUK  (aluk),
    .i_MUL   (mul),
    .i_START (start),
    .i_LD_CC (ldcc),
    .i_bus   (bus),
    .o_ALU   (alu),
    .o_VALID (vld),
    .o_BUSY  (busy),
    .o_N     (n),
    .o_Z     (z),
    .o_P     (p)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] opb_of(
    input logic [15:0] r2, input logic [15:0] i);
    int s;
    if (!i[5]) return r2;
    s = int'(i[4:0]);
    if (s >= 16) s = s - 32;
    return s[15:0];
  endfunction

  function automatic logic [15:0] ref_alu(
    input logic [1:0] k, input logic [15:0] a,
    input logic [15:0] b);
    int r;
    case (k)
      2'd0: r = int'(a) + int'(b);
      2'd1: r = int'(a & b);
      2'd2: r = 65535 - int'(a);
      default: r = int'(a);
    endcase
    return r[15:0];
  endfunction

  function automatic logic [2:0] ref_cc(input logic [15:0] v);
    if (v == 0) return 3'b010;
    if (v >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("cc_onehot", 16'($onehot({n, z, p})), 16'd1);
  endtask

  task automatic go(input logic [1:0] k, input logic [15:0] a,
                    input logic [15:0] b2, input logic [15:0] i);
    aluk = k; sr1 = a; sr2 = b2; ir = i; start = 1'b1;
    e_alu = ref_alu(k, a, opb_of(b2, i));
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sr1 = '0; sr2 = '0; ir = '0; bus = '0;
    aluk = '0; mul = 1'b0; start = 1'b0; ldcc = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_alu", alu, 16'h0000);
    chk("rst_vld", 16'(vld), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_cc", 16'({n, z, p}), 16'(3'b010));
    e_cc = 3'b010;

    go(2'd0, 16'h0005, 16'h1234, 16'h003D);
    chk("imm_add", alu, 16'h0002);
    chk("imm_vld", 16'(vld), 16'd1);
    step();
    chk("imm_vld_drop", 16'(vld), 16'd0);
    chk("imm_hold", alu, 16'h0002);

    go(2'd0, 16'h7FFF, 16'h0001, 16'h0000);
    chk("reg_add", alu, 16'h8000);
    go(2'd1, 16'hF0F0, 16'h0FF0, 16'h0000);
    chk("reg_and", alu, 16'h00F0);
    go(2'd2, 16'h00FF, 16'h0000, 16'h0000);
    chk("b2b_not", alu, 16'hFF00);
    chk("b2b_vld", 16'(vld), 16'd1);
    step();
    chk("b2b_drop", 16'(vld), 16'd0);

    ldcc = 1'b1;
    bus = 16'h8000; step();
    chk("cc_n", 16'({n, z, p}), 16'(3'b100));
    bus = 16'h0000; step();
    chk("cc_z", 16'({n, z, p}), 16'(3'b010));
    bus = 16'h0001; step();
    chk("cc_p", 16'({n, z, p}), 16'(3'b001));
    ldcc = 1'b0; bus = 16'h8000; step();
    chk("cc_hold", 16'({n, z, p}), 16'(3'b001));

    rst = 1'b1; ldcc = 1'b1; start = 1'b1; sr1 = 16'h1111;
    step();
    rst = 1'b0; ldcc = 1'b0; start = 1'b0;
    chk("prio_alu", alu, 16'h0000);
    chk("prio_vld", 16'(vld), 16'd0);
    chk("prio_cc", 16'({n, z, p}), 16'(3'b010));
    e_cc = 3'b010; e_alu = '0;

    for (int t = 0; t < 60; t++) begin
      logic [15:0] a, b2, i, bv;
      logic        s, l;
      a  = 16'($urandom); b2 = 16'($urandom);
      i  = 16'($urandom); bv = 16'($urandom);
      if (t % 7 == 0) bv = 16'h0000;
      s  = 1'($urandom); l = 1'($urandom);
      aluk = 2'($urandom); sr1 = a; sr2 = b2; ir = i;
      bus = bv; ldcc = l; start = s;
`ifndef ALU_MUL_EN
      mul = 1'($urandom);
`endif
      if (s) e_alu = ref_alu(aluk, a, opb_of(b2, i));
      if (l) e_cc = ref_cc(bv);
      step();
      chk("rnd_alu", alu, e_alu);
      chk("rnd_vld", 16'(vld), 16'(s));
      chk("rnd_cc", 16'({n, z, p}), 16'(e_cc));
      chk("rnd_busy", 16'(busy), 16'd0);
    end
    start = 1'b0; ldcc = 1'b0; mul = 1'b0;

`ifdef ALU_MUL_EN
    mul = 1'b1; sr1 = 16'h0003; sr2 = 16'hFFFF;
    ir = 16'h0000; start = 1'b1;
    step();
    start = 1'b0;
    chk("mul_busy1", 16'(busy), 16'd1);
    for (int c = 2; c <= 16; c++) begin
      start = (c == 6);
      if (c == 6) sr1 = 16'h0100;
      step();
      chk("mul_busy", 16'(busy), 16'd1);
      chk("mul_novld", 16'(vld), 16'd0);
    end
    start = 1'b0;
    step();
    chk("mul_done_busy", 16'(busy), 16'd0);
    chk("mul_done_vld", 16'(vld), 16'd1);
    chk("mul_prod", alu, 16'hFFFD);
    step();
    chk("mul_single_pulse", 16'(vld), 16'd0);
    chk("mul_no_queue", 16'(busy), 16'd0);

    for (int t = 0; t < 6; t++) begin
      logic [15:0] a, b2, i;
      int cyc;
      a = 16'($urandom); b2 = 16'($urandom);
      i = 16'($urandom);
      sr1 = a; sr2 = b2; ir = i; start = 1'b1;
      e_alu = 16'(32'(a) * 32'(opb_of(b2, i)));
      step();
      start = 1'b0; sr1 = ~a; sr2 = ~b2;
      cyc = 1;
      while (!vld && cyc < 40) begin
        step();
        cyc++;
      end
      chk("rmul_lat", 16'(cyc), 16'd17);
      chk("rmul_prod", alu, e_alu);
    end

    sr1 = 16'h1234; sr2 = 16'h0007; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 2; c <= 8; c++) step();
    chk("abort_busy8", 16'(busy), 16'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_alu", alu, 16'h0000);
    chk("abort_vld", 16'(vld), 16'd0);
    mul = 1'b0;
    go(2'd0, 16'h0010, 16'h0020, 16'h0000);
    chk("post_abort_add", alu, 16'h0030);
    chk("post_abort_vld", 16'(vld), 16'd1);
    for (int c = 0; c < 18; c++) begin
      step();
      chk("post_abort_quiet", 16'(vld), 16'd0);
    end
`else
    mul = 1'b1;
    go(2'd0, 16'h0002, 16'h0003, 16'h0000);
    chk("nomul_add", alu, 16'h0005);
    chk("nomul_vld", 16'(vld), 16'd1);
    chk("nomul_busy", 16'(busy), 16'd0);
    for (int c = 0; c < 18; c++) begin
      step();
      chk("nomul_busy_q", 16'(busy), 16'd0);
      chk("nomul_vld_q", 16'(vld), 16'd0);
    end
    mul = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
